// File: rtl/md_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// md_pkg : shared state/op encodings for the mul/div sequencer     rev 1.0
//------------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

  // LO value written for a divide by zero (HI gets the dividend)
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/md_lat_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// md_lat_counter : loadable down-counter with zero flag            rev 1.0
//------------------------------------------------------------------------------
module md_lat_counter
  import md_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so a stray decrement can never wrap
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/md_seq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// md_seq_ctrl : EX-stage mul/div sequencer (latency, stall, abort) rev 1.0
//------------------------------------------------------------------------------
module md_seq_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_ena_i,
  input  logic        div_ena_i,
  input  logic        mul_sign_i,
  input  logic        div_sign_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        flush_i,
  input  logic [31:0] mul_hi_i,
  input  logic [31:0] mul_lo_i,
  input  logic [31:0] div_q_i,
  input  logic [31:0] div_r_i,
  output logic [31:0] unit_a_o,
  output logic [31:0] unit_b_o,
  output logic        unit_mul_ena_o,
  output logic        unit_div_ena_o,
  output logic        unit_sign_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_wena_o
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_e   state_q, state_d;
  md_op_e      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sign_q, sign_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  logic req;
  logic div0;

  assign req  = (mul_ena_i | div_ena_i) & ~flush_i;
  assign div0 = div_ena_i & (rt_data_i == '0);

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    sign_d         = sign_q;
    cnt_load       = 1'b0;
    cnt_load_val   = MUL_LOAD;
    cnt_dec        = 1'b0;
    stall_o        = 1'b0;
    unit_mul_ena_o = 1'b0;
    unit_div_ena_o = 1'b0;
    hilo_wena_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall_o = 1'b1;
          a_d     = rs_data_i;
          b_d     = rt_data_i;
          op_d    = div_ena_i ? OP_DIV : OP_MUL;
          sign_d  = div_ena_i ? div_sign_i : mul_sign_i;
          // Divide by zero has a fixed answer, so the units are bypassed
          if (div0) begin
            hi_d    = rs_data_i;
            lo_d    = DIV0_LO;
            state_d = ST_DONE;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = div_ena_i ? DIV_LOAD : MUL_LOAD;
            state_d      = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        unit_mul_ena_o = (op_q == OP_MUL);
        unit_div_ena_o = (op_q == OP_DIV);
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt_zero) begin
            if (op_q == OP_MUL) begin
              hi_d = mul_hi_i;
              lo_d = mul_lo_i;
            end else begin
              hi_d = div_r_i;
              lo_d = div_q_i;
            end
            state_d = ST_DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // The pipeline advances at this edge, so any visible request is stale
        hilo_wena_o = ~flush_i;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sign_q  <= sign_d;
    end
  end

  assign unit_a_o    = a_q;
  assign unit_b_o    = b_q;
  assign unit_sign_o = sign_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
